// File: rtl/logic_result_stage.sv
// Registered output stage behind the logic unit: tags each result with status flags
// and buffers it in a small FIFO toward writeback, counting completed operations.
module logic_result_stage #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_f,
  input  logic [WIDTH-1:0]   in_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [3:0]         out_f,
  output logic               out_zero,
  output logic               out_neg,
  output logic               out_err,
  output logic [COUNT_W-1:0] op_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       f;
    logic             zero;
    logic             neg;
    logic             err;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             head_q, head_d;
  entry_t             new_entry;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [COUNT_W-1:0] op_count_q, op_count_d;
  logic               push, pop, illegal;

  assign in_ready  = (occ_q != OCC_W'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Illegal op codes store a zero result so downstream sees a clean, flagged entry.
  always_comb begin
    illegal            = (in_f[3:2] != 2'b00) || (in_f[1:0] == 2'b00);
    new_entry          = '0;
    new_entry.f        = in_f;
    new_entry.result   = illegal ? '0 : in_result;
    new_entry.zero     = (new_entry.result == '0);
    new_entry.neg      = new_entry.result[WIDTH-1];
    new_entry.err      = illegal;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    op_count_d = op_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      op_count_d = op_count_q + COUNT_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // The head is re-registered so out_* never see in_* combinationally; when the
  // next head is the entry being written this cycle it is taken from the decode.
  always_comb begin
    head_d = head_q;
    if (occ_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        head_d = new_entry;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      op_count_q <= '0;
      head_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      op_count_q <= op_count_d;
      head_q     <= head_d;
    end
  end

  assign out_result = head_q.result;
  assign out_f      = head_q.f;
  assign out_zero   = head_q.zero;
  assign out_neg    = head_q.neg;
  assign out_err    = head_q.err;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_logic_result_stage.sv
// Self-checking bench for logic_result_stage: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_logic_result_stage;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int COUNT_W = 16;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       f;
    logic             zero;
    logic             neg;
    logic             err;
  } entry_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [3:0]         in_f = '0;
  logic [WIDTH-1:0]   in_result = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [WIDTH-1:0]   out_result;
  logic [3:0]         out_f;
  logic               out_zero, out_neg, out_err;
  logic [COUNT_W-1:0] op_count;

  entry_t             modelQ[$];
  entry_t             lastHead;
  logic [COUNT_W-1:0] modelCount;
  int                 checks = 0;
  int                 failures = 0;
  string              phase = "init";

  logic_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_f(out_f), .out_zero(out_zero), .out_neg(out_neg), .out_err(out_err),
    .op_count(op_count)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic entry_t expectEntry(input logic [3:0] f, input logic [WIDTH-1:0] r);
    entry_t e;
    logic bad;
    bad      = (f[3:2] != 2'b00) || (f[1:0] == 2'b00);
    e.f      = f;
    e.result = bad ? '0 : r;
    e.zero   = (e.result == '0);
    e.neg    = e.result[WIDTH-1];
    e.err    = bad;
    return e;
  endfunction

  task automatic compareAll();
    checkOutput("out_valid", 64'(out_valid), 64'(modelQ.size() != 0));
    checkOutput("in_ready", 64'(in_ready), 64'(modelQ.size() != DEPTH));
    checkOutput("op_count", 64'(op_count), 64'(modelCount));
    checkOutput("out_result", 64'(out_result), 64'(lastHead.result));
    checkOutput("out_f", 64'(out_f), 64'(lastHead.f));
    checkOutput("flags", 64'({out_zero, out_neg, out_err}),
                64'({lastHead.zero, lastHead.neg, lastHead.err}));
  endtask

  // One clock of traffic: drive, check model against DUT, then advance the model.
  task automatic applyStimulus(input logic v, input logic [3:0] f, input logic [WIDTH-1:0] r,
                               input logic rdy, output logic accepted);
    logic doPush, doPop;
    in_valid  = v;
    in_f      = f;
    in_result = r;
    out_ready = rdy;
    #4;
    compareAll();
    doPush = v && (modelQ.size() < DEPTH);
    doPop  = rdy && (modelQ.size() > 0);
    @(posedge clk);
    #1;
    if (doPop) begin
      void'(modelQ.pop_front());
      modelCount = modelCount + 1'b1;
    end
    if (doPush) modelQ.push_back(expectEntry(f, r));
    if (modelQ.size() != 0) lastHead = modelQ[0];
    accepted = doPush;
  endtask

  task automatic resetDut(input logic keepValid);
    rst      = 1'b1;
    in_valid = keepValid;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    modelQ.delete();
    modelCount = '0;
    lastHead   = '0;
  endtask

  initial begin
    logic acc;
    logic pend;
    logic [3:0] rf;
    logic [WIDTH-1:0] rr;
    logic rv;

    phase = "t1_reset";
    resetDut(1'b0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_count", 64'(op_count), 64'd0);
    checkOutput("rst_result", 64'(out_result), 64'd0);
    applyStimulus(1'b0, 4'h0, '0, 1'b0, acc);

    phase = "t2_and";
    applyStimulus(1'b1, 4'b0001, 32'h0000_00F0, 1'b1, acc);
    checkOutput("valid", 64'(out_valid), 64'd1);
    checkOutput("result", 64'(out_result), 64'h0000_00F0);
    checkOutput("flags", 64'({out_zero, out_neg, out_err}), 64'd0);
    applyStimulus(1'b0, 4'h0, '0, 1'b1, acc);
    checkOutput("count", 64'(op_count), 64'd1);

    phase = "t3_flags";
    applyStimulus(1'b1, 4'b0011, 32'h8000_0000, 1'b0, acc);
    applyStimulus(1'b1, 4'b0000, 32'hFFFF_FFFF, 1'b0, acc);
    checkOutput("e1_neg_err", 64'({out_neg, out_err}), 64'b10);
    applyStimulus(1'b0, 4'h0, '0, 1'b1, acc);
    checkOutput("e2_result", 64'(out_result), 64'd0);
    checkOutput("e2_flags", 64'({out_zero, out_neg, out_err}), 64'b101);
    applyStimulus(1'b0, 4'h0, '0, 1'b1, acc);

    phase = "t4_full";
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0010, 32'h100 + 32'(i), 1'b0, acc);
    checkOutput("full_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 4'b0010, 32'h104, 1'b0, acc);
      checkOutput("held", 64'(acc), 64'd0);
    end
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) applyStimulus(1'b1, 4'b0010, 32'h104, 1'b1, acc);
    checkOutput("fifth_accept", 64'(acc), 64'd1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'h0, '0, 1'b1, acc);

    phase = "t5_stream";
    resetDut(1'b0);
    for (int i = 0; i <= 10; i++)
      applyStimulus(i < 10, 4'b0011, 32'hA000 + 32'(i), i > 0, acc);
    applyStimulus(1'b0, 4'h0, '0, 1'b0, acc);
    checkOutput("count10", 64'(op_count), 64'd10);

    phase = "t6_midreset";
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0001, 32'h55 + 32'(i), 1'b0, acc);
    in_f = 4'b0001;
    in_result = 32'h77;
    resetDut(1'b1);
    checkOutput("valid", 64'(out_valid), 64'd0);
    checkOutput("ready", 64'(in_ready), 64'd1);
    checkOutput("count", 64'(op_count), 64'd0);

    phase = "random";
    pend = 1'b0;
    rv = 1'b0;
    rf = '0;
    rr = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        rv = ($urandom_range(0, 3) != 0);
        rf = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 7))
          0:       rr = '0;
          1:       rr = 32'h8000_0000;
          default: rr = $urandom;
        endcase
      end
      applyStimulus(rv, rf, rr, $urandom_range(0, 2) != 0, acc);
      pend = rv && !acc;
    end
    applyStimulus(1'b0, 4'h0, '0, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
